// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and widths: the {pc, instr} entry carried from fetch to decode.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;
  localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = 32'h0;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the queue's occupancy count.
module fetch_queue_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               CLK,
  input  logic               i_wrEn,
  input  logic [PTR_W-1:0]   i_wrPtr,
  input  fetch_entry_t       i_wrData,
  input  logic [PTR_W-1:0]   i_rdPtr,
  output fetch_entry_t       o_rdData
);

  fetch_entry_t r_mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (i_wrEn) begin
      r_mem[i_wrPtr] <= i_wrData;
    end
  end

  assign o_rdData = r_mem[i_rdPtr];

endmodule

// File: rtl/fetch_inst_queue.sv
// Prefetch instruction queue between fetch and decode, with single-cycle flush on redirect.
// Optional stall statistics counter is enabled with `define FETCH_QUEUE_STATS_EN.
module fetch_inst_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = FETCH_DATA_W,
  parameter int ADDR_W = FETCH_ADDR_W
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_pc,
  input  logic [DATA_W-1:0]      in_instr,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W-1:0]      out_pc,
  output logic [DATA_W-1:0]      out_instr,
  output logic [$clog2(DEPTH):0] count
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [15:0]            stall_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  fetch_entry_t     w_wrEntry;
  fetch_entry_t     w_rdEntry;

  // in_ready depends only on registered state and reset, never on out_ready.
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign in_ready  = !w_full && !RST;
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign count     = r_count;

  assign w_wrEntry.pc    = FETCH_ADDR_W'(in_pc);
  assign w_wrEntry.instr = FETCH_DATA_W'(in_instr);

  fetch_queue_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .CLK      (CLK),
    .i_wrEn   (w_push && !flush),
    .i_wrPtr  (r_wrPtr),
    .i_wrData (w_wrEntry),
    .i_rdPtr  (r_rdPtr),
    .o_rdData (w_rdEntry)
  );

  assign out_pc    = out_valid ? ADDR_W'(w_rdEntry.pc)    : '0;
  assign out_instr = out_valid ? DATA_W'(w_rdEntry.instr) : '0;

  // Pointers wrap naturally at DEPTH; the separate count tells full from empty.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

`ifdef FETCH_QUEUE_STATS_EN
  logic [15:0] r_stallCnt;

  // Counts back-pressured fetch cycles; survives flush so redirects do not hide stalls.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stallCnt <= '0;
    end else if (in_valid && !in_ready && (r_stallCnt != 16'hFFFF)) begin
      r_stallCnt <= r_stallCnt + 16'd1;
    end
  end

  assign stall_cnt = r_stallCnt;
`endif

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Directed self-checking bench for fetch_inst_queue (stall counter checks under FETCH_QUEUE_STATS_EN).
module tb_fetch_inst_queue;

  logic        CLK;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;
`ifdef FETCH_QUEUE_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int passCnt  = 0;
  int totalCnt = 0;

  fetch_inst_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(32)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .count     (count)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    RST = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;

    // Reset asserted mid-cycle takes effect immediately
    #3 RST = 1'b1;
    #1;
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_pc", out_pc, 32'h0);
    checkOutput("rst_out_instr", out_instr, 32'h0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    #8 RST = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
    applyStimulus();

    // Fill to full with decode stalled
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'(4 * i); in_instr = 32'hA0 + 32'(i);
      applyStimulus();
      checkOutput("fill_count", 32'(count), 32'(i + 1));
      checkOutput("fill_head_pc", out_pc, 32'h0);
    end
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    in_pc = 32'h10; in_instr = 32'hA4;
    applyStimulus();
    checkOutput("full_drop_count", 32'(count), 32'd4);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_pc", out_pc, 32'(4 * i));
      checkOutput("drain_instr", out_instr, 32'hA0 + 32'(i));
      applyStimulus();
      checkOutput("drain_count", 32'(count), 32'(3 - i));
    end
    checkOutput("drained_out_valid", 32'(out_valid), 32'd0);
    checkOutput("drained_out_pc", out_pc, 32'h0);
    applyStimulus();
    checkOutput("drop_never_seen", 32'(out_valid), 32'd0);

    // Streaming at occupancy 1, wrapping pointers past DEPTH
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h0; in_instr = 32'hB0;
    applyStimulus();
    checkOutput("stream_start_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    for (int i = 1; i < 10; i++) begin
      in_pc = 32'(4 * i); in_instr = 32'hB0 + 32'(i);
      checkOutput("stream_pc", out_pc, 32'(4 * (i - 1)));
      applyStimulus();
      checkOutput("stream_count", 32'(count), 32'd1);
    end
    in_valid = 1'b0;
    checkOutput("stream_last_pc", out_pc, 32'h24);
    checkOutput("stream_last_instr", out_instr, 32'hB9);
    applyStimulus();
    checkOutput("stream_end_count", 32'(count), 32'd0);

    // Flush at count 3 discards simultaneous push and pop
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_pc = 32'h200 + 32'(4 * i); in_instr = 32'hC0 + 32'(i);
      applyStimulus();
    end
    checkOutput("pre_flush_count", 32'(count), 32'd3);
    flush = 1'b1; in_pc = 32'h100; in_instr = 32'hDEAD; out_ready = 1'b1;
    applyStimulus();
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("flush_count", 32'(count), 32'd0);
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_out_pc", out_pc, 32'h0);
    applyStimulus();
    checkOutput("flush_no_0x100", 32'(out_valid), 32'd0);

    // Push on empty: no bypass, visible the next cycle
    in_valid = 1'b1; in_pc = 32'h40; in_instr = 32'h55; out_ready = 1'b1;
    #1;
    checkOutput("empty_push_cycle_valid", 32'(out_valid), 32'd0);
    applyStimulus();
    in_valid = 1'b0; out_ready = 1'b0;
    checkOutput("empty_push_valid", 32'(out_valid), 32'd1);
    checkOutput("empty_push_pc", out_pc, 32'h40);
    checkOutput("empty_push_instr", out_instr, 32'h55);
    out_ready = 1'b1;
    applyStimulus();
    checkOutput("empty_push_drain", 32'(count), 32'd0);

    // Pop at full does not enable a push in the same cycle
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_pc = 32'h80 + 32'(4 * i); in_instr = 32'hE0 + 32'(i);
      applyStimulus();
    end
    in_pc = 32'h300; in_instr = 32'hFF; out_ready = 1'b1;
    applyStimulus();
    in_valid = 1'b0;
    checkOutput("full_pop_count", 32'(count), 32'd3);
    for (int i = 1; i < 4; i++) begin
      checkOutput("full_pop_pc", out_pc, 32'h80 + 32'(4 * i));
      applyStimulus();
    end
    checkOutput("full_pop_empty", 32'(out_valid), 32'd0);

    // Reset mid-operation clears state without a clock edge
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h500; in_instr = 32'h1;
    applyStimulus();
    applyStimulus();
    in_valid = 1'b0;
    checkOutput("pre_rst_count", 32'(count), 32'd2);
    RST = 1'b1;
    #1;
    checkOutput("async_rst_count", 32'(count), 32'd0);
    checkOutput("async_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("async_rst_out_pc", out_pc, 32'h0);
`ifdef FETCH_QUEUE_STATS_EN
    checkOutput("async_rst_stall", 32'(stall_cnt), 32'd0);
`endif
    #2 RST = 1'b0;
    applyStimulus();
    checkOutput("post_async_rst_ready", 32'(in_ready), 32'd1);

`ifdef FETCH_QUEUE_STATS_EN
    // Hold full with fetch still presenting: five stall cycles
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_pc = 32'h600 + 32'(4 * i);
      applyStimulus();
    end
    checkOutput("stats_fill_stall", 32'(stall_cnt), 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus();
    in_valid = 1'b0;
    checkOutput("stats_stall5", 32'(stall_cnt), 32'd5);
    flush = 1'b1;
    applyStimulus();
    flush = 1'b0;
    checkOutput("stats_after_flush", 32'(stall_cnt), 32'd5);
    RST = 1'b1;
    #1;
    checkOutput("stats_after_rst", 32'(stall_cnt), 32'd0);
    #2 RST = 1'b0;
    applyStimulus();
`endif

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
